truth_table_checker: RTL and testbench

//  On-FPGA stimulus/response end for the lab's 4-input combinational DUTs (default golden: y = a&~b | c&~d).

---
 rtl/truth_table_checker_pkg.sv | 29 ++
 rtl/truth_table_checker_settle_timer.sv | 37 +++
 rtl/truth_table_checker.sv | 121 ++++++++++++
 tb/tb_truth_table_checker.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/truth_table_checker_pkg.sv
// ============================================================================
// Module : truth_table_checker_pkg
// Brief  : State encodings, lab golden truth tables and sizing helper shared
//          by the truth-table checker.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package truth_table_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } tt_state_e;

    // Golden tables, bit k = expected y for input vector k = {a,b,c,d}
    localparam logic [15:0] TT_ABBAR_CDBAR = 16'h4F44;
    localparam logic [15:0] TT_ABBAR       = 16'h0F00;

    // Counter width able to hold 0..n-1, never narrower than one bit
    function automatic int unsigned tt_cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/truth_table_checker_settle_timer.sv
// ============================================================================
// Module : tt_settle_timer
// Brief  : Clear/enable cycle counter that flags the last settle cycle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tt_settle_timer
    import truth_table_checker_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int unsigned         CW   = tt_cnt_width(SETTLE_CYCLES);
    localparam logic [CW-1:0]       LAST = CW'(SETTLE_CYCLES - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expire_o = en_i && (cnt_q == LAST);

endmodule

`default_nettype wire

// File: rtl/truth_table_checker.sv
// ============================================================================
// Module : truth_table_checker
// Brief  : Sweeps every input vector of a small combinational DUT, compares
//          its response to a golden table and reports the verdict.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module truth_table_checker
    import truth_table_checker_pkg::*;
#(
    parameter int                     N_IN          = 4,
    parameter int                     SETTLE_CYCLES = 1,
    parameter logic [(1<<N_IN)-1:0]   EXPECTED      = TT_ABBAR_CDBAR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [N_IN-1:0] dut_in,
    input  logic            dut_y,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic            first_fail_valid,
    output logic [N_IN-1:0] first_fail_idx
);

    localparam logic [N_IN-1:0] LAST_IDX = '1;

    tt_state_e       state_q;
    logic [N_IN-1:0] idx_q;
    logic [N_IN:0]   err_q;
    logic            ffv_q;
    logic [N_IN-1:0] ffi_q;
    logic            busy_q;
    logic            done_q;
    logic            pass_q;

    logic            w_accept;
    logic            w_timer_clr;
    logic            w_expire;
    logic            w_mismatch;
    logic [N_IN:0]   w_err_nxt;

    assign w_accept    = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && start;
    assign w_timer_clr = w_accept || (state_q == ST_CHECK);
    assign w_mismatch  = dut_y ^ EXPECTED[idx_q];
    assign w_err_nxt   = err_q + {{N_IN{1'b0}}, w_mismatch};

    tt_settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (w_timer_clr),
        .en_i     (state_q == ST_SETTLE),
        .expire_o (w_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            err_q   <= '0;
            ffv_q   <= 1'b0;
            ffi_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q <= ST_SETTLE;
                        idx_q   <= '0;
                        err_q   <= '0;
                        ffv_q   <= 1'b0;
                        ffi_q   <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (w_expire) begin
                        state_q <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    err_q <= w_err_nxt;
                    if (w_mismatch && !ffv_q) begin
                        ffv_q <= 1'b1;
                        ffi_q <= idx_q;
                    end
                    // Verdict uses the updated count so the last vector is included
                    if (idx_q == LAST_IDX) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (w_err_nxt == '0);
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                        state_q <= ST_SETTLE;
                    end
                end
            endcase
        end
    end

    assign dut_in           = idx_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign err_count        = err_q;
    assign first_fail_valid = ffv_q;
    assign first_fail_idx   = ffi_q;

endmodule

`default_nettype wire

// File: tb/tb_truth_table_checker.sv
// ============================================================================
// Module : tb_truth_table_checker
// Brief  : Directed bench for truth_table_checker with behavioural lab DUTs.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_truth_table_checker;
    import truth_table_checker_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       start3;
    int         mode;
    int         total = 0;
    int         bad   = 0;

    logic [3:0] dut_in,  dut_in3;
    logic       dut_y,   dut_y3;
    logic       busy,    busy3;
    logic       done,    done3;
    logic       pass,    pass3;
    logic [4:0] err,     err3;
    logic       ffv,     ffv3;
    logic [3:0] ffi,     ffi3;

    always #5 clk = ~clk;

    // mode 0: golden a&~b | c&~d, mode 1: stuck-at-0, mode 2: a&~b only
    function automatic logic lab_dut(input int m, input logic [3:0] v);
        logic a, b, c, d;
        {a, b, c, d} = v;
        case (m)
            0:       return (a & ~b) | (c & ~d);
            1:       return 1'b0;
            default: return a & ~b;
        endcase
    endfunction

    always_comb dut_y  = lab_dut(mode, dut_in);
    always_comb dut_y3 = lab_dut(0, dut_in3);

    truth_table_checker u_dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .dut_in           (dut_in),
        .dut_y            (dut_y),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .err_count        (err),
        .first_fail_valid (ffv),
        .first_fail_idx   (ffi)
    );

    truth_table_checker #(.SETTLE_CYCLES(3)) u_dut3 (
        .clk              (clk),
        .rst              (rst),
        .start            (start3),
        .dut_in           (dut_in3),
        .dut_y            (dut_y3),
        .busy             (busy3),
        .done             (done3),
        .pass             (pass3),
        .err_count        (err3),
        .first_fail_valid (ffv3),
        .first_fail_idx   (ffi3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Counts edges from the start-accepting edge until done is seen
    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic run_sweep(output int n);
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        wait_done(n);
    endtask

    int n;

    initial begin
        rst = 1'b1; start = 1'b0; start3 = 1'b0; mode = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err",  err,  0);
        check("rst_ffv",  ffv,  0);
        check("rst_dutin", dut_in, 0);
        @(negedge clk); rst = 1'b0;

        mode = 0; run_sweep(n);
        check("t1_edge", n, 32);
        check("t1_pass", pass, 1);
        check("t1_err",  err,  0);
        check("t1_ffv",  ffv,  0);
        check("t1_busy", busy, 0);

        mode = 1; run_sweep(n);
        check("t2_edge", n, 32);
        check("t2_err",  err, 7);
        check("t2_pass", pass, 0);
        check("t2_ffv",  ffv, 1);
        check("t2_ffi",  ffi, 2);

        mode = 2; run_sweep(n);
        check("t3_edge", n, 32);
        check("t3_err",  err, 3);
        check("t3_pass", pass, 0);
        check("t3_ffi",  ffi, 2);

        mode = 1;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        n = 0;
        while (dut_in != 4'd5 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("t4_reach5", dut_in, 5);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("t4_busy",  busy, 0);
        check("t4_done",  done, 0);
        check("t4_err",   err,  0);
        check("t4_ffv",   ffv,  0);
        check("t4_ffi",   ffi,  0);
        check("t4_dutin", dut_in, 0);
        @(negedge clk); rst = 1'b0;
        mode = 0; run_sweep(n);
        check("t4_edge", n, 32);
        check("t4_pass", pass, 1);

        mode = 1;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1;
        wait_done(n);
        check("t5_edge", n, 32);
        check("t5_err",  err, 7);
        @(posedge clk); #1;
        check("t5_done_drop", done, 0);
        check("t5_busy",  busy, 1);
        check("t5_err_clr", err, 0);
        check("t5_ffv_clr", ffv, 0);
        check("t5_dutin", dut_in, 0);
        start = 1'b0;
        wait_done(n);
        check("t5_edge2", n, 32);

        @(negedge clk); start3 = 1'b1;
        @(posedge clk); #1; start3 = 1'b0;
        n = 0;
        while (!done3 && n < 300) begin
            @(posedge clk); #1;
            n++;
            if (n == 3) check("t6_hold", dut_in3, 0);
            if (n == 4) check("t6_next", dut_in3, 1);
        end
        check("t6_edge", n, 64);
        check("t6_pass", pass3, 1);
        check("t6_err",  err3, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
